// File: rtl/sram_arbiter_if.sv
// CPU-side request/ack bundle for the SRAM arbiter: instruction-fetch port and data port.
// The pipeline drives the master side and the arbiter is the slave.
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        inst_busy;

  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_busy;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_be, data_addr, data_wdata,
    input  inst_ack, inst_rdata, inst_busy, data_ack, data_rdata, data_busy
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_be, data_addr, data_wdata,
    output inst_ack, inst_rdata, inst_busy, data_ack, data_rdata, data_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares BaseRAM/ExtRAM between the fetch and data ports: one access at a time, data has
// priority unless fetch has waited MAX_DATA_BURST data grants.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  sram_arbiter_if.slave bus,

  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,

  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n
);

  localparam int unsigned StreakW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_BURST);
  localparam logic [2:0] WaitLoad = 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1: data port, 0: inst port
  logic                bank_q, bank_d;    // 1: ExtRAM, 0: BaseRAM
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [19:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                inst_ack_q, inst_ack_d;
  logic                data_ack_q, data_ack_d;
  logic [31:0]         inst_rdata_q, inst_rdata_d;
  logic [31:0]         data_rdata_q, data_rdata_d;

  logic        grant_data, grant_inst;
  logic [31:0] rd_word;
  logic        in_xfer, sel_base, sel_ext, drive_base, drive_ext;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_addr[31:23], bus.inst_addr[1:0],
                              bus.data_addr[31:23], bus.data_addr[1:0]};

  assign rd_word = bank_q ? ext_ram_data : base_ram_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      bank_q       <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      streak_q     <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bank_q       <= bank_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bank_d       = bank_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    grant_data   = 1'b0;
    grant_inst   = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_data = bus.data_req && !(bus.inst_req && (streak_q == StreakMax));
        grant_inst = bus.inst_req && !grant_data;
        if (grant_data || grant_inst) begin
          state_d = StAccess;
          owner_d = grant_data;
          bank_d  = grant_data ? bus.data_addr[22] : bus.inst_addr[22];
          addr_d  = grant_data ? bus.data_addr[21:2] : bus.inst_addr[21:2];
          we_d    = grant_data && bus.data_we;
          be_d    = grant_data ? bus.data_be : 4'b0000;
          wdata_d = grant_data ? bus.data_wdata : 32'h0;
          cnt_d   = WaitLoad;
        end
        // Streak only grows while fetch is actually being held off.
        if (grant_data) begin
          if (!bus.inst_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (grant_inst) begin
          streak_d = '0;
        end
      end
      StAccess: begin
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          if (owner_q) begin
            data_ack_d = 1'b1;
            if (!we_q) data_rdata_d = rd_word;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = rd_word;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes only in ACCESS; a write holds its data and byte enables through DONE.
  always_comb begin
    in_xfer    = (state_q != StIdle);
    sel_base   = (state_q == StAccess) && !bank_q;
    sel_ext    = (state_q == StAccess) && bank_q;
    drive_base = in_xfer && we_q && !bank_q;
    drive_ext  = in_xfer && we_q && bank_q;

    base_ram_ce_n = !sel_base;
    base_ram_oe_n = !(sel_base && !we_q);
    base_ram_we_n = !(sel_base && we_q && (be_q != 4'b0000));
    base_ram_be_n = drive_base ? ~be_q : 4'b0000;
    base_ram_addr = (in_xfer && !bank_q) ? addr_q : 20'h0;

    ext_ram_ce_n  = !sel_ext;
    ext_ram_oe_n  = !(sel_ext && !we_q);
    ext_ram_we_n  = !(sel_ext && we_q && (be_q != 4'b0000));
    ext_ram_be_n  = drive_ext ? ~be_q : 4'b0000;
    ext_ram_addr  = (in_xfer && bank_q) ? addr_q : 20'h0;
  end

  assign base_ram_data = drive_base ? wdata_q : 32'bz;
  assign ext_ram_data  = drive_ext ? wdata_q : 32'bz;

  assign bus.inst_ack   = inst_ack_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.inst_busy  = in_xfer && !owner_q;
  assign bus.data_ack   = data_ack_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_busy  = in_xfer && owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAMs on the pins, a word-array reference memory,
// and per-port expected-response queues popped by a monitor on every ack.
module tb_sram_arbiter;
  localparam int unsigned WaitCycles = 1;
  localparam int unsigned MaxBurst   = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  sram_arbiter #(.WAIT_CYCLES(WaitCycles), .MAX_DATA_BURST(MaxBurst)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int bank, input int i);
    if (bank == 0 && i == 4) return 32'hDEAD_BEEF;
    return {(bank != 0) ? 8'hE7 : 8'hBA, 8'(i), 8'(i * 3), 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Pin-level SRAMs: drive reads combinationally, commit byte writes at the clock edge.
  logic [31:0] base_mem [256];
  logic [31:0] ext_mem  [256];
  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'bz;
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'bz;

  initial begin
    for (int i = 0; i < 256; i++) begin
      base_mem[i] = init_word(0, i);
      ext_mem[i]  = init_word(1, i);
    end
    forever begin
      @(posedge clk);
      if (!base_ram_ce_n && !base_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!base_ram_be_n[b]) base_mem[base_ram_addr[7:0]][8*b +: 8] = base_ram_data[8*b +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!ext_ram_be_n[b]) ext_mem[ext_ram_addr[7:0]][8*b +: 8] = ext_ram_data[8*b +: 8];
    end
  end

  // Reference: what each word should hold, and what each port's rdata should show.
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_ird, last_drd;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];

  task automatic push_inst(input logic [31:0] addr);
    last_ird = ref_mem[addr[22]][addr[9:2]];
    exp_i_q.push_back(last_ird);
  endtask

  task automatic push_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wd);
    if (we) begin
      ref_mem[addr[22]][addr[9:2]] = merge(ref_mem[addr[22]][addr[9:2]], wd, be);
    end else begin
      last_drd = ref_mem[addr[22]][addr[9:2]];
    end
    exp_d_q.push_back(last_drd);
  endtask

  always @(negedge clk) begin
    chk("ce_overlap", 32'(!base_ram_ce_n && !ext_ram_ce_n), 32'd0);
    chk("addr_hi", {8'h0, base_ram_addr[19:8], ext_ram_addr[19:8]}, 32'd0);
    if (bus.inst_ack) begin
      if (exp_i_q.size() == 0) chk("inst_ack_unexpected", 32'(bus.inst_ack), 32'd0);
      else chk("inst_rdata", bus.inst_rdata, exp_i_q.pop_front());
    end
    if (bus.data_ack) begin
      if (exp_d_q.size() == 0) chk("data_ack_unexpected", 32'(bus.data_ack), 32'd0);
      else chk("data_rdata", bus.data_rdata, exp_d_q.pop_front());
    end
  end

  // Called just after a negedge; returns at the negedge where the ack is seen.
  task automatic inst_txn(input logic [31:0] addr);
    bit got = 1'b0;
    push_inst(addr);
    bus.inst_addr = addr;
    bus.inst_req  = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.inst_ack) got = 1'b1;
      else if (bus.inst_busy) bus.inst_addr = $urandom();
    end
    bus.inst_req = 1'b0;
    chk("inst_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic data_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
    bit got = 1'b0;
    push_data(we, be, addr, wd);
    bus.data_we    = we;
    bus.data_be    = be;
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    bus.data_req   = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.data_ack) got = 1'b1;
      else if (bus.data_busy) begin
        bus.data_addr  = $urandom();
        bus.data_wdata = $urandom();
        bus.data_be    = 4'($urandom());
        bus.data_we    = 1'($urandom());
      end
    end
    bus.data_req = 1'b0;
    chk("data_ack_seen", 32'(got), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr(input logic bank, input int word);
    logic [31:0] r = $urandom();
    return {r[31:23], bank, 12'h0, 8'(word), r[1:0]};
  endfunction

  initial begin
    int d_cyc, i_cyc, nd;
    logic [31:0] ord;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d_cyc, i_cyc, nd;
    logic [31:0] ord;
    for (int i = 0; i < 256; i++) begin
      ref_mem[0][i] = init_word(0, i);
      ref_mem[1][i] = init_word(1, i);
    end
    last_ird = '0;
    last_drd = '0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_be = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;

    // Reset held with a pending fetch: everything idle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_strobes", {26'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                          ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h3F);
      chk("rst_be_n", {24'h0, base_ram_be_n, ext_ram_be_n}, 32'h0);
      chk("rst_ack_busy", {28'h0, bus.inst_ack, bus.data_ack, bus.inst_busy, bus.data_busy}, 32'h0);
      chk("rst_rdata", bus.inst_rdata | bus.data_rdata, 32'h0);
    end
    push_inst(32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("first_grant_busy", 32'(bus.inst_busy), 32'd1);
    @(negedge clk);
    chk("first_ack", 32'(bus.inst_ack), 32'd1);
    bus.inst_req = 1'b0;

    // Directed fetch from BaseRAM word 4.
    @(negedge clk);
    push_inst(32'h8000_0010);
    bus.inst_addr = 32'h8000_0010; bus.inst_req = 1'b1;
    @(negedge clk);
    chk("rd_base_addr", base_ram_addr, 32'h4);
    chk("rd_base_strobes", {29'h0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n}, 32'b001);
    chk("rd_ext_idle", {29'h0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'b111);
    @(negedge clk);
    chk("rd_ack", 32'(bus.inst_ack), 32'd1);
    chk("rd_done_strobes", {30'h0, base_ram_ce_n, base_ram_oe_n}, 32'b11);
    bus.inst_req = 1'b0;

    // Directed partial write to ExtRAM word 2.
    @(negedge clk);
    push_data(1'b1, 4'b0011, 32'h8040_0008, 32'h1234_5678);
    bus.data_we = 1'b1; bus.data_be = 4'b0011;
    bus.data_addr = 32'h8040_0008; bus.data_wdata = 32'h1234_5678; bus.data_req = 1'b1;
    @(negedge clk);
    bus.data_wdata = 32'hFFFF_FFFF;
    chk("wr_ext_addr", ext_ram_addr, 32'h2);
    chk("wr_ext_strobes", {29'h0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'b010);
    chk("wr_be_n", {28'h0, ext_ram_be_n}, 32'b1100);
    chk("wr_bus", ext_ram_data, 32'h1234_5678);
    chk("wr_base_idle", 32'(base_ram_ce_n), 32'd1);
    @(negedge clk);
    chk("wr_ack", 32'(bus.data_ack), 32'd1);
    chk("wr_hold_bus", ext_ram_data, 32'h1234_5678);
    chk("wr_done_strobes", {30'h0, ext_ram_ce_n, ext_ram_we_n}, 32'b11);
    bus.data_req = 1'b0;

    // Write with no byte enables: full timing, we_n never asserted.
    @(negedge clk);
    push_data(1'b1, 4'b0000, 32'h0040_0208, 32'hA5A5_A5A5);
    bus.data_be = 4'b0000; bus.data_addr = 32'h0040_0208; bus.data_req = 1'b1;
    @(negedge clk);
    chk("be0_strobes", {30'h0, ext_ram_ce_n, ext_ram_we_n}, 32'b01);
    @(negedge clk);
    chk("be0_ack", 32'(bus.data_ack), 32'd1);
    bus.data_req = 1'b0;

    // Simultaneous requests: data first, fetch right after.
    @(negedge clk);
    push_data(1'b0, 4'h0, 32'h8000_0100, 32'h0);
    push_inst(32'h8000_0020);
    bus.data_we = 1'b0; bus.data_addr = 32'h8000_0100; bus.data_req = 1'b1;
    bus.inst_addr = 32'h8000_0020; bus.inst_req = 1'b1;
    d_cyc = 0; i_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.data_ack) begin d_cyc = c; bus.data_req = 1'b0; end
      if (bus.inst_ack) begin i_cyc = c; bus.inst_req = 1'b0; end
    end
    chk("simul_data_ack_cycle", 32'(d_cyc), 32'd2);
    chk("simul_inst_ack_cycle", 32'(i_cyc), 32'd5);

    // Starvation guard: continuous data traffic lets fetch in after MaxBurst grants.
    @(negedge clk);
    for (int k = 0; k < 5; k++) push_data(1'b0, 4'h0, 32'h0040_0200, 32'h0);
    push_inst(32'h0000_0040);
    bus.data_addr = 32'h0040_0200; bus.data_req = 1'b1;
    bus.inst_addr = 32'h0000_0040; bus.inst_req = 1'b1;
    ord = 32'h1; nd = 0;
    for (int c = 0; c < 40 && nd < 5; c++) begin
      @(negedge clk);
      if (bus.data_ack) begin
        ord = {ord[30:0], 1'b0}; nd++;
        if (nd == 5) bus.data_req = 1'b0;
      end
      if (bus.inst_ack) begin ord = {ord[30:0], 1'b1}; bus.inst_req = 1'b0; end
    end
    chk("starve_order", ord, 32'b100_0010);

    // Reset in the middle of a write: abort, no ack, rdata cleared.
    @(negedge clk);
    bus.data_we = 1'b1; bus.data_be = 4'hF; bus.data_addr = 32'h0040_0370;
    bus.data_wdata = 32'h0BAD_F00D; bus.data_req = 1'b1;
    @(negedge clk);
    chk("abort_we_active", 32'(ext_ram_we_n), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {28'h0, ext_ram_ce_n, ext_ram_we_n, base_ram_ce_n, base_ram_we_n}, 32'hF);
    chk("abort_no_ack", {30'h0, bus.data_ack, bus.data_busy}, 32'h0);
    chk("abort_rdata", bus.data_rdata | bus.inst_rdata, 32'h0);
    resetn = 1'b1; bus.data_req = 1'b0;
    last_ird = '0; last_drd = '0;
    repeat (4) @(negedge clk);

    // Random concurrent traffic; fetch reads words 0..127, data uses 128..191.
    fork
      for (int t = 0; t < 40; t++) begin
        inst_txn(rand_addr(1'($urandom()), int'($urandom_range(0, 127))));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int t = 0; t < 60; t++) begin
        data_txn(1'($urandom()), 4'($urandom()),
                 rand_addr(1'($urandom()), int'($urandom_range(128, 191))), $urandom());
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join
    repeat (6) @(negedge clk);
    chk("inst_q_drained", 32'(exp_i_q.size()), 32'd0);
    chk("data_q_drained", 32'(exp_d_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
